// File: rtl/ram_line_pkg.sv
// ram_line_pkg: shared types and helpers for the RAM-side line controller.
// The pattern helper is only referenced when RAM_LINE_CTRL_PATTERN_EN is defined.
package ram_line_pkg;

    // A line is always carried as four beats, low word first.
    localparam int unsigned BEATS_PER_LINE = 4;

    // Widths the generated pattern is defined for: {beat[1:0], 1'b0, line_addr[12:0]}.
    localparam int unsigned PAT_ADDR_W = 13;
    localparam int unsigned PAT_BEAT_W = 16;

    typedef logic [1:0] beat_idx_t;

    typedef enum logic [2:0] {
        StIdle,
        StWCollect,
        StWAck,
        StRWait,
        StRBurst
    } state_e;

    // Beat returned for a line that has not been written since reset.
    function automatic logic [PAT_BEAT_W-1:0] pattern_beat(input beat_idx_t      k,
                                                           input logic [PAT_ADDR_W-1:0] line_addr);
        return {k, 1'b0, line_addr};
    endfunction

endpackage

// File: rtl/ram_line_array.sv
// ram_line_array: line storage, one synchronous write port and one combinational read port.
// With RAM_LINE_CTRL_PATTERN_EN defined it also keeps one valid bit per line, cleared by reset;
// otherwise there are no valid bits and the storage starts out zeroed in simulation.
module ram_line_array #(
    parameter int unsigned ADDR_SIZE = 13,
    parameter int unsigned LINE_SIZE = 64
) (
    input  logic                 clk,
`ifdef RAM_LINE_CTRL_PATTERN_EN
    input  logic                 rst_n,
    output logic                 rvalid,
`endif
    input  logic                 we,
    input  logic [ADDR_SIZE-1:0] waddr,
    input  logic [LINE_SIZE-1:0] wdata,
    input  logic [ADDR_SIZE-1:0] raddr,
    output logic [LINE_SIZE-1:0] rdata
);

    localparam int unsigned NUM_LINES = 2 ** ADDR_SIZE;

`ifdef RAM_LINE_CTRL_PATTERN_EN
    // Contents are never reset; the valid bits decide whether they are visible.
    logic [LINE_SIZE-1:0] mem [NUM_LINES];
    logic [NUM_LINES-1:0] valid_q;

    // Valid bits: cleared asynchronously by reset, set by every completed line write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else if (we) begin
            valid_q[waddr] <= 1'b1;
        end
    end

    assign rvalid = valid_q[raddr];
`else
    logic [LINE_SIZE-1:0] mem [NUM_LINES] = '{default: '0};
`endif

    // Line write, committed on the edge that samples the last beat.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/ram_line_ctrl.sv
// ram_line_ctrl: terminates the cache RAM port. Writes arrive as four beats on consecutive
// cycles, reads return four beats after READ_LAT cycles. Beat, ack and data outputs are
// registered; ram_busy is decoded from the state.
// Optional feature: RAM_LINE_CTRL_PATTERN_EN -- reads of lines not written since reset return
// a generated pattern instead of the array contents.
module ram_line_ctrl
    import ram_line_pkg::*;
#(
    parameter int unsigned ADDR_SIZE = 13,
    parameter int unsigned BEAT_SIZE = 16,
    parameter int unsigned LINE_SIZE = 64,  // must be 4 * BEAT_SIZE
    parameter int unsigned READ_LAT  = 4    // 1..15
) (
    input  logic                 ram_clk,
    input  logic                 ram_rst_n,
    input  logic [ADDR_SIZE-1:0] ram_addr,
    input  logic                 ram_avalid,
    input  logic                 ram_rnw,
    input  logic [BEAT_SIZE-1:0] ram_wdata,
    output logic [BEAT_SIZE-1:0] ram_rdata,
    output logic                 ram_ack,
    output logic                 ram_busy
);

    // Beat 0 is registered on the edge before the first ack cycle, so the wait state covers
    // READ_LAT-1 edges; a counter value of 0 means "leave RWAIT on this edge".
    localparam logic [3:0] LAT_LOAD = (READ_LAT > 1) ? 4'(READ_LAT - 2) : 4'd0;

    state_e               state_q;
    logic [ADDR_SIZE-1:0] addr_q;
    beat_idx_t            beat_q;
    logic [3:0]           lat_q;
    logic [BEAT_SIZE-1:0] wbuf_q [3];
    logic                 ack_q;
    logic [BEAT_SIZE-1:0] rdata_q;

    logic                 arr_we;
    logic [LINE_SIZE-1:0] arr_wline;
    logic [LINE_SIZE-1:0] arr_rline;
    logic [ADDR_SIZE-1:0] rd_addr;
    beat_idx_t            rd_idx;
    logic [BEAT_SIZE-1:0] arr_beat;
    logic [BEAT_SIZE-1:0] rd_beat;

    // Read addressing: in IDLE the incoming address is used so a READ_LAT of 1 can register
    // beat 0 on the request edge itself.
    always_comb begin
        rd_addr = (state_q == StIdle) ? ram_addr : addr_q;
        rd_idx  = (state_q == StRBurst) ? beat_q : '0;
    end

    // Beat disassembly, low word first.
    always_comb begin
        arr_beat = '0;
        case (rd_idx)
            2'd0:    arr_beat = arr_rline[0*BEAT_SIZE +: BEAT_SIZE];
            2'd1:    arr_beat = arr_rline[1*BEAT_SIZE +: BEAT_SIZE];
            2'd2:    arr_beat = arr_rline[2*BEAT_SIZE +: BEAT_SIZE];
            default: arr_beat = arr_rline[3*BEAT_SIZE +: BEAT_SIZE];
        endcase
    end

    // The line is written on the edge that samples beat 3, so a following read sees it.
    assign arr_we    = (state_q == StWCollect) && ram_avalid && (beat_q == 2'd3);
    assign arr_wline = {ram_wdata, wbuf_q[2], wbuf_q[1], wbuf_q[0]};

`ifdef RAM_LINE_CTRL_PATTERN_EN
    logic arr_rvalid;

    assign rd_beat = arr_rvalid ? arr_beat
                                : BEAT_SIZE'(pattern_beat(rd_idx, PAT_ADDR_W'(rd_addr)));

    ram_line_array #(
        .ADDR_SIZE(ADDR_SIZE),
        .LINE_SIZE(LINE_SIZE)
    ) u_array (
        .clk   (ram_clk),
        .rst_n (ram_rst_n),
        .rvalid(arr_rvalid),
        .we    (arr_we),
        .waddr (addr_q),
        .wdata (arr_wline),
        .raddr (rd_addr),
        .rdata (arr_rline)
    );
`else
    assign rd_beat = arr_beat;

    ram_line_array #(
        .ADDR_SIZE(ADDR_SIZE),
        .LINE_SIZE(LINE_SIZE)
    ) u_array (
        .clk  (ram_clk),
        .we   (arr_we),
        .waddr(addr_q),
        .wdata(arr_wline),
        .raddr(rd_addr),
        .rdata(arr_rline)
    );
`endif

    // Main FSM with registered ack/data outputs. Requests outside IDLE/WCOLLECT are ignored.
    always_ff @(posedge ram_clk or negedge ram_rst_n) begin
        if (!ram_rst_n) begin
            state_q <= StIdle;
            addr_q  <= '0;
            beat_q  <= '0;
            lat_q   <= '0;
            wbuf_q  <= '{default: '0};
            ack_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            ack_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (ram_avalid) begin
                        addr_q <= ram_addr;
                        if (ram_rnw) begin
                            if (READ_LAT == 1) begin
                                ack_q   <= 1'b1;
                                rdata_q <= rd_beat;
                                beat_q  <= 2'd1;
                                state_q <= StRBurst;
                            end else begin
                                lat_q   <= LAT_LOAD;
                                state_q <= StRWait;
                            end
                        end else begin
                            wbuf_q[0] <= ram_wdata;
                            beat_q    <= 2'd1;
                            state_q   <= StWCollect;
                        end
                    end
                end
                StWCollect: begin
                    if (!ram_avalid) begin
                        // Gap in the beat stream: drop the partial line silently.
                        beat_q  <= '0;
                        state_q <= StIdle;
                    end else if (beat_q == 2'd3) begin
                        ack_q   <= 1'b1;
                        beat_q  <= '0;
                        state_q <= StWAck;
                    end else begin
                        wbuf_q[beat_q] <= ram_wdata;
                        beat_q         <= beat_q + 2'd1;
                    end
                end
                StWAck: begin
                    state_q <= StIdle;
                end
                StRWait: begin
                    if (lat_q == 4'd0) begin
                        ack_q   <= 1'b1;
                        rdata_q <= rd_beat;
                        beat_q  <= 2'd1;
                        state_q <= StRBurst;
                    end else begin
                        lat_q <= lat_q - 4'd1;
                    end
                end
                StRBurst: begin
                    // The index has wrapped back to 0 once beat 3 is on the bus.
                    if (beat_q == 2'd0) begin
                        rdata_q <= '0;
                        state_q <= StIdle;
                    end else begin
                        ack_q   <= 1'b1;
                        rdata_q <= rd_beat;
                        beat_q  <= beat_q + 2'd1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign ram_ack   = ack_q;
    assign ram_rdata = rdata_q;
    assign ram_busy  = (state_q != StIdle);

endmodule

// File: tb/tb_ram_line_ctrl.sv
// tb_ram_line_ctrl: drives two controllers (READ_LAT 4 and 1) with the same traffic and checks
// every ack against a scoreboard filled by a line-level reference model.
module tb_ram_line_ctrl;

    localparam int unsigned ADDR_SIZE = 13;
    localparam int unsigned BEAT_SIZE = 16;
    localparam int unsigned LINE_SIZE = 64;
    localparam int unsigned LAT0      = 4;
    localparam int unsigned LAT1      = 1;

    logic                 clk   = 1'b0;
    logic                 rst_n = 1'b1;
    logic [ADDR_SIZE-1:0] addr;
    logic                 avalid;
    logic                 rnw;
    logic [BEAT_SIZE-1:0] wdata;
    logic [BEAT_SIZE-1:0] rdata0, rdata1;
    logic                 ack0, ack1, busy0, busy1;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        bit          wr;
        logic [15:0] data;
        int          cyc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    // Reference model: line contents and "written since reset" flags.
    logic [63:0] mem_m [int];
    bit          vld_m [int];

    ram_line_ctrl #(
        .ADDR_SIZE(ADDR_SIZE), .BEAT_SIZE(BEAT_SIZE), .LINE_SIZE(LINE_SIZE), .READ_LAT(LAT0)
    ) u_dut0 (
        .ram_clk(clk), .ram_rst_n(rst_n), .ram_addr(addr), .ram_avalid(avalid), .ram_rnw(rnw),
        .ram_wdata(wdata), .ram_rdata(rdata0), .ram_ack(ack0), .ram_busy(busy0)
    );

    ram_line_ctrl #(
        .ADDR_SIZE(ADDR_SIZE), .BEAT_SIZE(BEAT_SIZE), .LINE_SIZE(LINE_SIZE), .READ_LAT(LAT1)
    ) u_dut1 (
        .ram_clk(clk), .ram_rst_n(rst_n), .ram_addr(addr), .ram_avalid(avalid), .ram_rnw(rnw),
        .ram_wdata(wdata), .ram_rdata(rdata1), .ram_ack(ack1), .ram_busy(busy1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic logic [15:0] exp_beat(input int a, input int k);
        logic [63:0] line;
        line = mem_m.exists(a) ? mem_m[a] : 64'd0;
`ifdef RAM_LINE_CTRL_PATTERN_EN
        if (!vld_m.exists(a)) return 16'(k * 16384 + a);
`endif
        return line[16*k +: 16];
    endfunction

    // Pops the next expected ack for one port; also flags acks that never arrived.
    task automatic mon_port(input int p, input logic ack, input logic [15:0] rd);
        exp_t e;
        int   n;
        n = (p == 0) ? q0.size() : q1.size();
        if (ack) begin
            if (n == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ack%0d: ack=1 at cycle %0d, expected no ack", p, cyc);
            end else begin
                if (p == 0) e = q0.pop_front();
                else        e = q1.pop_front();
                chk($sformatf("ack_cycle%0d", p), cyc, e.cyc);
                if (!e.wr) chk($sformatf("rd_beat%0d", p), 32'(rd), 32'(e.data));
            end
        end else if (n != 0) begin
            e = (p == 0) ? q0[0] : q1[0];
            if (e.cyc <= cyc) begin
                checks++;
                errors++;
                $display("FAIL missing_ack%0d: ack=0 at cycle %0d, expected ack", p, cyc);
                if (p == 0) void'(q0.pop_front());
                else        void'(q1.pop_front());
            end
        end
    endtask

    // Monitor: compares whatever the DUTs present, independent of the stimulus thread.
    always @(negedge clk) begin
        if (rst_n) begin
            mon_port(0, ack0, rdata0);
            mon_port(1, ack1, rdata1);
        end
    end

    // Returns at a falling edge with both controllers idle.
    task automatic wait_idle();
        int n = 0;
        while ((busy0 || busy1) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (busy0 || busy1) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: busy0=%0b busy1=%0b, expected 0", busy0, busy1);
        end
    endtask

    task automatic do_write(input int a, input logic [63:0] line, input int abort_at);
        int   e;
        exp_t x;
        wait_idle();
        e = cyc + 1;
        if (abort_at == 0) begin
            x.wr = 1'b1; x.data = '0; x.cyc = e + 3;
            q0.push_back(x);
            q1.push_back(x);
            mem_m[a] = line;
            vld_m[a] = 1'b1;
        end
        for (int b = 0; b < 4; b++) begin
            if (abort_at != 0 && b == abort_at) break;
            avalid = 1'b1;
            rnw    = 1'b0;
            addr   = 13'(a);
            wdata  = line[16*b +: 16];
            @(negedge clk);
            chk("wr_busy0", 32'(busy0), 1);
            chk("wr_busy1", 32'(busy1), 1);
        end
        avalid = 1'b0;
        wdata  = 16'($urandom);
        if (abort_at != 0) begin
            @(negedge clk);
            chk("abort_busy0", 32'(busy0), 0);
            chk("abort_busy1", 32'(busy1), 0);
        end
    endtask

    task automatic do_read(input int a, input bit pulse);
        int   e;
        exp_t x;
        wait_idle();
        e = cyc + 1;
        for (int k = 0; k < 4; k++) begin
            x.wr = 1'b0; x.data = exp_beat(a, k);
            x.cyc = e + int'(LAT0) + k - 1;
            q0.push_back(x);
            x.cyc = e + int'(LAT1) + k - 1;
            q1.push_back(x);
        end
        avalid = 1'b1;
        rnw    = 1'b1;
        addr   = 13'(a);
        @(negedge clk);
        if (pulse) begin
            // Stray request while both units are mid-read; must have no effect.
            rnw   = 1'($urandom_range(0, 1));
            addr  = 13'($urandom);
            wdata = 16'($urandom);
            @(negedge clk);
        end
        avalid = 1'b0;
    endtask

    initial begin
        int          a;
        int          op;
        logic [63:0] line;

        avalid = 1'b0;
        rnw    = 1'b0;
        addr   = '0;
        wdata  = '0;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_ack0", 32'(ack0), 0);
        chk("rst_rdata0", 32'(rdata0), 0);
        chk("rst_busy0", 32'(busy0), 0);
        chk("rst_ack1", 32'(ack1), 0);
        chk("rst_rdata1", 32'(rdata1), 0);
        chk("rst_busy1", 32'(busy1), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Read of an unwritten line, then write and read back.
        do_read('h1579, 1'b0);
        do_write('h1579, 64'hDEAD_BEEF_DEAD_F00D, 0);
        do_read('h1579, 1'b0);

        // Aborted write leaves the line untouched.
        do_write('h0200, 64'h1111_2222_3333_4444, 2);
        do_read('h0200, 1'b0);

        // Write immediately followed by a read of the same line; address extremes.
        do_write('h1E01, 64'hCAFE_0123_4567_89AB, 0);
        do_read('h1E01, 1'b0);
        do_write('h1FFF, 64'hFFFF_0000_A5A5_5A5A, 0);
        do_read('h1FFF, 1'b0);
        do_write('h0000, 64'h0001_0002_0003_0004, 0);
        do_read('h0000, 1'b0);

        // Ignored request during the read wait.
        do_read('h1E01, 1'b1);

        // Reset during the second beat of a read burst.
        do_read('h1579, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        chk("pre_rst_ack0", 32'(ack0), 1);
        q0.delete();
        q1.delete();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ack0", 32'(ack0), 0);
        chk("mid_rst_rdata0", 32'(rdata0), 0);
        chk("mid_rst_busy0", 32'(busy0), 0);
        chk("mid_rst_busy1", 32'(busy1), 0);
        vld_m.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        do_read('h1579, 1'b0);

        // Random traffic over a small address pool plus occasional far addresses.
        for (int i = 0; i < 60; i++) begin
            op = int'($urandom_range(0, 9));
            a  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 8191))
                                              : int'($urandom_range(0, 7));
            line = {$urandom, $urandom};
            if (op <= 3) begin
                do_write(a, line, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
            end else if (op <= 8) begin
                do_read(a, 1'($urandom_range(0, 1)));
            end else begin
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
        end

        wait_idle();
        repeat (8) @(negedge clk);
        chk("queue_empty", 32'(q0.size() + q1.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_line_ctrl.md
# ram_line_ctrl

Synthesizable RAM-side controller that terminates the cache's RAM port and replaces the behavioural RAM stub in system builds. It accepts 64-bit line reads and writes as four 16-bit beats over the existing `ram_*` bus, stores lines in an internal array indexed by the 13-bit line address, and returns read lines as a four-beat burst after a fixed latency. It sits directly downstream of `full_cache` in the `ram_clk` domain.

## Interface
- `ADDR_SIZE`, 13: line address width (tag + index).
- `BEAT_SIZE`, 16: data beat width.
- `LINE_SIZE`, 64: line width; must equal 4 × `BEAT_SIZE`.
- `READ_LAT`, 4: cycles from the read request cycle to the first read beat; legal range 1..15.

Ports:
- `ram_clk` in 1: controller clock.
- `ram_rst_n` in 1: asynchronous active-low reset.
- `ram_addr` in `ADDR_SIZE`: line address, sampled in the request cycle.
- `ram_avalid` in 1: request / write-beat valid.
- `ram_rnw` in 1: 1 = read, 0 = write; sampled in the request cycle.
- `ram_wdata` in `BEAT_SIZE`: write beat.
- `ram_rdata` out `BEAT_SIZE`: read beat, registered.
- `ram_ack` out 1: read-beat valid, or write-done pulse; registered.
- `ram_busy` out 1: high in every state except IDLE.

## Operation
- States: IDLE, WCOLLECT, WACK, RWAIT, RBURST.
- IDLE: when `ram_avalid`=1, latch `ram_addr` and `ram_rnw`.
  - Write: store beat 0 and go to WCOLLECT.
  - Read: load the latency counter and go to RWAIT.
- WCOLLECT: beats 1..3 are taken on the next three cycles and require `ram_avalid`=1 on each.
  - If `ram_avalid`=0 on any of these cycles, abort: go to IDLE with no array write and no ack.
  - After beat 3, write `{b3,b2,b1,b0}` to the array, set the line's valid bit, and go to WACK.
- WACK: `ram_ack`=1 for one cycle, then go to IDLE.
- RWAIT: count down, then go to RBURST.
- RBURST: drive beats 0..3 (low word first) with `ram_ack`=1 on four consecutive cycles, then go to IDLE.
- Any `ram_avalid` seen outside IDLE or WCOLLECT is ignored. The cache must hold it low until `ram_busy` falls.
- Beat index is a 2-bit counter that wraps 3→0 at burst end.
- Reset mid-operation: immediately go to IDLE. `ram_ack`=0, `ram_rdata`=0, `ram_busy`=0. All valid bits are cleared. Array data is not cleared. A partially collected write is discarded.

## Timing
- Cycle 0 is the rising edge at which the request is sampled in IDLE.
- Write: beats are sampled at cycles 0,1,2,3. `ram_ack` is high during cycle 4 only. `ram_busy` is high over cycles 1..4. The next request is accepted at cycle 5.
- Read: `ram_ack` and beats are valid during cycles `READ_LAT`..`READ_LAT`+3. The next request is accepted at cycle `READ_LAT`+4.
- Read-after-write to the same line returns the new data; there is no bypass hazard because the array write completes in cycle 4.
- Reset values: `ram_rdata`=0, `ram_ack`=0, `ram_busy`=0, state=IDLE.

## Configuration
- `RAM_LINE_CTRL_PATTERN_EN` defined: a read of a line whose valid bit is 0 returns a generated pattern instead of array contents. Beat k is `{k[1:0], 1'b0, line_addr}`.
- Not defined: valid bits are not implemented, reads always return array contents, and the array is zero-initialised for simulation.

## Structure
- Shared package `ram_line_pkg`:
  - Contents: the state enum, `BEATS_PER_LINE`=4, beat-index type, and the pattern-generation function.
- Sub-module `ram_line_array`:
  - Contents: 2^`ADDR_SIZE` × `LINE_SIZE` storage with one synchronous write port and one read port.
  - Holds the valid-bit flops when `RAM_LINE_CTRL_PATTERN_EN` is defined.
- `ram_line_ctrl` holds the FSM, beat assembly and disassembly, and the latency counter.

## Test plan
- Read miss with pattern enabled: read `0x1579` → `ram_ack` high on cycles 4..7 with beats `0x1579`, `0x5579`, `0x9579`, `0xD579`.
- Write then read:
  - Write `0x1579` with beats `F00D`, `DEAD`, `BEEF`, `DEAD` → one-cycle ack at cycle 4.
  - Read `0x1579` → beats `F00D`, `DEAD`, `BEEF`, `DEAD`.
- Aborted write:
  - Write `0x0200` with `ram_avalid` dropped at beat 2 → no ack, `ram_busy` low at cycle 3.
  - Then read `0x0200` → pattern data.
- Back-to-back traffic: write `0x1E01` immediately followed by a read of `0x1E01` at cycle 5, with `READ_LAT`=1 → beats valid at cycles 6..9 (cycles 1..4 of the read) and match the written data.
- Reset during RBURST: assert `ram_rst_n`=0 at the second read beat → `ram_ack`, `ram_rdata` and `ram_busy` go to 0 asynchronously, and the previously written line now reads back as pattern.
- Ignored request: `ram_avalid` pulsed during RWAIT → the burst is unchanged and no extra ack occurs.
